mem_arbiter: RTL and testbench

Single-port data/instruction memory arbiter for the core. It shares one synchronous single-port RAM between the fetch port and the load/store port, and grants one access per cycle with load/store priority and a starvation guard for fetch. For each granted access it generates the word address, byte enables and lane-replicated write data, and checks alignment. Read data is returned right-justified on the following cycle to the load/store sign-extension stage, whose encoding matches `lsCtrl`.

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port RAM between fetch and load/store, one access per cycle.
// Load/store wins contention, except that fetch is forced through after STARVE_MAX straight losses.
module mem_arbiter #(
   parameter int SIZE       = 12,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ifReq,
   input  logic [31:0]     ifAddr,
   output logic            ifGnt,
   output logic            ifRvalid,
   output logic [31:0]     ifRdata,
   input  logic            lsReq,
   input  logic [2:0]      lsCtrl,
   input  logic [31:0]     lsAddr,
   input  logic [31:0]     lsWdata,
   output logic            lsGnt,
   output logic            lsRvalid,
   output logic [31:0]     lsRdata,
   output logic            lsErr,
   output logic            memEn,
   output logic            memWe,
   output logic [3:0]      memBe,
   output logic [SIZE-3:0] memAddr,
   output logic [31:0]     memWdata,
   input  logic [31:0]     memRdata
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic             if_pend_q, if_pend_d;
   logic             ls_pend_q, ls_pend_d;
   logic             ls_err_q, ls_err_d;
   logic             ls_load_q, ls_load_d;
   logic [1:0]       ls_off_q, ls_off_d;
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   logic       ls_write, size_b, size_h, size_w, ls_mis, fetch_forced;
   logic [1:0] ls_off;
   logic       unused_addr_bits;

   assign unused_addr_bits = ^{ifAddr[31:SIZE], ifAddr[1:0], lsAddr[31:SIZE]};

   // Access-type decode; codes 101..111 are the stores.
   always_comb begin
      ls_off   = lsAddr[1:0];
      ls_write = lsCtrl[2] & (lsCtrl[1] | lsCtrl[0]);
      size_b   = 1'b0;
      size_h   = 1'b0;
      size_w   = 1'b0;
      case (lsCtrl)
         3'b000, 3'b011, 3'b101: size_b = 1'b1;
         3'b001, 3'b100, 3'b110: size_h = 1'b1;
         default:                size_w = 1'b1;
      endcase
      ls_mis = (size_h & ls_off[0]) | (size_w & (ls_off != 2'b00));
   end

   always_comb begin
      fetch_forced = (starve_cnt_q == CNT_MAX);
      ifGnt        = !rst & ifReq & (!lsReq | fetch_forced);
      lsGnt        = !rst & lsReq & !(ifReq & fetch_forced);
      starve_cnt_d = starve_cnt_q;
      if (ifGnt) begin
         starve_cnt_d = '0;
      end else if (lsGnt & ifReq) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_comb begin
      memEn    = 1'b0;
      memWe    = 1'b0;
      memBe    = 4'b0000;
      memAddr  = '0;
      memWdata = '0;
      if (ifGnt) begin
         memEn   = 1'b1;
         memBe   = 4'b1111;
         memAddr = ifAddr[SIZE-1:2];
      end else if (lsGnt) begin
         // A misaligned access is still granted but never strobes the RAM.
         memEn   = !ls_mis;
         memWe   = ls_write;
         memAddr = lsAddr[SIZE-1:2];
         if (size_b) begin
            memBe = 4'b0001 << ls_off;
         end else if (size_h) begin
            memBe = 4'b0011 << ls_off;
         end else begin
            memBe = 4'b1111;
         end
         if (ls_write) begin
            if (size_b) begin
               memWdata = {4{lsWdata[7:0]}};
            end else if (size_h) begin
               memWdata = {2{lsWdata[15:0]}};
            end else begin
               memWdata = lsWdata;
            end
         end
      end
   end

   always_comb begin
      if_pend_d = ifGnt;
      ls_pend_d = lsGnt;
      ls_err_d  = lsGnt & ls_mis;
      ls_load_d = lsGnt & !ls_write;
      ls_off_d  = lsGnt ? ls_off : 2'b00;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_pend_q    <= 1'b0;
         ls_pend_q    <= 1'b0;
         ls_err_q     <= 1'b0;
         ls_load_q    <= 1'b0;
         ls_off_q     <= 2'b00;
         starve_cnt_q <= '0;
      end else begin
         if_pend_q    <= if_pend_d;
         ls_pend_q    <= ls_pend_d;
         ls_err_q     <= ls_err_d;
         ls_load_q    <= ls_load_d;
         ls_off_q     <= ls_off_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // Responses come straight from the pending flags, so reset kills them at once.
   assign ifRvalid = if_pend_q;
   assign ifRdata  = if_pend_q ? memRdata : 32'h0;
   assign lsRvalid = ls_pend_q;
   assign lsErr    = ls_pend_q & ls_err_q;
   assign lsRdata  = (ls_pend_q & !ls_err_q & ls_load_q) ? (memRdata >> {ls_off_q, 3'b000}) : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural RAM behind the memory port, and expected
// responses queued at grant time and retired one cycle later.
module tb_mem_arbiter;

   localparam int SIZE       = 12;
   localparam int STARVE_MAX = 4;
   localparam int AW         = SIZE - 2;
   localparam int DEPTH      = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ifReq = 1'b0;
   logic [31:0]   ifAddr = '0;
   logic          ifGnt, ifRvalid;
   logic [31:0]   ifRdata;
   logic          lsReq = 1'b0;
   logic [2:0]    lsCtrl = '0;
   logic [31:0]   lsAddr = '0;
   logic [31:0]   lsWdata = '0;
   logic          lsGnt, lsRvalid, lsErr;
   logic [31:0]   lsRdata;
   logic          memEn, memWe;
   logic [3:0]    memBe;
   logic [AW-1:0] memAddr;
   logic [31:0]   memWdata, memRdata;

   always #5 clk = ~clk;

   mem_arbiter #(.SIZE(SIZE), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt), .ifRvalid(ifRvalid), .ifRdata(ifRdata),
      .lsReq(lsReq), .lsCtrl(lsCtrl), .lsAddr(lsAddr), .lsWdata(lsWdata), .lsGnt(lsGnt),
      .lsRvalid(lsRvalid), .lsRdata(lsRdata), .lsErr(lsErr),
      .memEn(memEn), .memWe(memWe), .memBe(memBe), .memAddr(memAddr), .memWdata(memWdata),
      .memRdata(memRdata)
   );

   function automatic logic [31:0] init_word(int i);
      if (i == 1) return 32'hBEEF1234;
      return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50000;
   endfunction

   // Synchronous RAM; filled on the first clock edge while reset is still held.
   logic        ram_ready = 1'b0;
   logic [31:0] ram [DEPTH];
   logic [31:0] rdata_q = '0;
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
         ram_ready <= 1'b1;
      end else if (memEn) begin
         for (int b = 0; b < 4; b++)
            if (memWe && memBe[b]) ram[memAddr][8*b +: 8] <= memWdata[8*b +: 8];
         rdata_q <= ram[memAddr];
      end
   end
   assign memRdata = rdata_q;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] if_exp_q [$];
   logic [32:0] ls_exp_q [$];
   logic [31:0] ref_mem [DEPTH];
   int          exp_starve = 0;
   logic        obs_if_gnt, obs_ls_gnt;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Retires queued responses; runs at posedge+3 so grants pushed at the
   // previous negedge are exactly the ones due now.
   task automatic response_monitor();
      logic [31:0] e_if;
      logic [32:0] e_ls;
      forever begin
         @(posedge clk);
         #3;
         if (!rst) begin
            if (if_exp_q.size() != 0) begin
               e_if = if_exp_q.pop_front();
               check("if_rvalid", ifRvalid, 1);
               check("if_rdata", ifRdata, e_if);
            end else begin
               check("if_idle", {ifRvalid, ifRdata}, 0);
            end
            if (ls_exp_q.size() != 0) begin
               e_ls = ls_exp_q.pop_front();
               check("ls_rvalid", lsRvalid, 1);
               check("ls_resp", {lsErr, lsRdata}, e_ls);
            end else begin
               check("ls_idle", {lsRvalid, lsErr, lsRdata}, 0);
            end
         end
      end
   endtask

   // Drives one cycle of requests (called at posedge+1), checks grant and memory command at negedge.
   task automatic step(input logic i_if_req, input logic [31:0] i_if_addr, input logic i_ls_req,
                       input logic [2:0] i_ls_ctrl, input logic [31:0] i_ls_addr,
                       input logic [31:0] i_ls_wdata);
      logic          e_if, e_ls, wr, mis;
      logic [1:0]    off;
      logic [3:0]    be;
      logic [31:0]   wd;
      logic [AW-1:0] wa;
      logic [47:0]   exp_cmd;
      int            sz;
      ifReq   = i_if_req;
      ifAddr  = i_if_addr;
      lsReq   = i_ls_req;
      lsCtrl  = i_ls_ctrl;
      lsAddr  = i_ls_addr;
      lsWdata = i_ls_wdata;
      @(negedge clk);
      e_if = i_if_req && (!i_ls_req || exp_starve == STARVE_MAX);
      e_ls = i_ls_req && !e_if;
      obs_if_gnt = ifGnt;
      obs_ls_gnt = lsGnt;
      check("if_gnt", ifGnt, e_if);
      check("ls_gnt", lsGnt, e_ls);
      exp_cmd = '0;
      if (e_if) begin
         wa = i_if_addr[SIZE-1:2];
         exp_cmd = {1'b1, 1'b0, 4'hF, wa, 32'h0};
         if_exp_q.push_back(ref_mem[wa]);
      end else if (e_ls) begin
         wa  = i_ls_addr[SIZE-1:2];
         off = i_ls_addr[1:0];
         case (i_ls_ctrl)
            3'd0, 3'd3, 3'd5: sz = 0;
            3'd1, 3'd4, 3'd6: sz = 1;
            default:          sz = 2;
         endcase
         wr  = (i_ls_ctrl >= 3'd5);
         mis = (sz == 1 && off[0]) || (sz == 2 && off != 2'b00);
         be  = (sz == 0) ? (4'b0001 << off) : (sz == 1) ? (4'b0011 << off) : 4'hF;
         wd  = !wr ? 32'h0 : (sz == 0) ? {4{i_ls_wdata[7:0]}} :
               (sz == 1) ? {2{i_ls_wdata[15:0]}} : i_ls_wdata;
         exp_cmd = {!mis, wr, be, wa, wd};
         ls_exp_q.push_back({mis, (!wr && !mis) ? (ref_mem[wa] >> (8 * off)) : 32'h0});
         if (wr && !mis)
            for (int b = 0; b < 4; b++) if (be[b]) ref_mem[wa][8*b +: 8] = wd[8*b +: 8];
      end
      check("mem_cmd", {memEn, memWe, memBe, memAddr, memWdata}, exp_cmd);
      if (e_if) exp_starve = 0;
      else if (e_ls && i_if_req) exp_starve++;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] fa, la, c_if_addr, c_ls_addr, c_ls_wdata;
   logic        c_if_req, c_ls_req;
   logic [2:0]  c_ls_ctrl;

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      fork response_monitor(); join_none

      // Reset held with both requesters asking.
      ifReq = 1'b1; lsReq = 1'b1; lsCtrl = 3'b111; lsAddr = 32'h10; lsWdata = 32'hFFFF_FFFF;
      ifAddr = 32'h20;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_gnt", {ifGnt, lsGnt}, 0);
      check("rst_mem", {memEn, memWe, memBe, memAddr, memWdata}, 0);
      check("rst_resp", {ifRvalid, lsRvalid, lsErr, ifRdata}, 0);
      check("rst_lsrdata", lsRdata, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Sustained contention: LS x4 then IF, twice.
      fa = $urandom;
      for (int i = 0; i < 10; i++) begin
         la = $urandom;
         la[1:0] = 2'b00;
         step(1'b1, fa, 1'b1, 3'b010, la, 32'h0);
         check("cont_pattern", {obs_if_gnt, obs_ls_gnt}, (i % 5 == 4) ? 2'b10 : 2'b01);
         if (obs_if_gnt) fa = $urandom;
      end

      step(1'b0, 32'h0, 1'b1, 3'b101, 32'h0000_0102, 32'h0000_00AB);
      check("sb_done", {lsRvalid, lsErr}, 2'b10);
      step(1'b0, 32'h0, 1'b1, 3'b001, 32'h0000_0006, 32'h0);
      check("lh_rdata", lsRdata, 32'h0000_BEEF);
      step(1'b0, 32'h0, 1'b1, 3'b010, 32'h0000_0005, 32'h0);
      check("lw_mis", {lsRvalid, lsErr, lsRdata}, {2'b11, 32'h0});
      step(1'b1, 32'h0000_0100, 1'b0, 3'b000, 32'h0, 32'h0);

      // Random traffic; an ungranted requester holds its request.
      c_if_req = 1'b1; c_if_addr = $urandom;
      c_ls_req = 1'b1; c_ls_ctrl = 3'($urandom_range(0, 7)); c_ls_addr = $urandom; c_ls_wdata = $urandom;
      for (int i = 0; i < 80; i++) begin
         step(c_if_req, c_if_addr, c_ls_req, c_ls_ctrl, c_ls_addr, c_ls_wdata);
         if (obs_if_gnt || !c_if_req) begin
            c_if_req  = ($urandom_range(0, 3) != 0);
            c_if_addr = $urandom;
         end
         if (obs_ls_gnt || !c_ls_req) begin
            c_ls_req   = ($urandom_range(0, 3) != 0);
            c_ls_ctrl  = 3'($urandom_range(0, 7));
            c_ls_addr  = $urandom;
            c_ls_wdata = $urandom;
         end
      end

      // Reset in the response cycle of a fetch drops the response.
      step(1'b1, 32'h0000_0040, 1'b0, 3'b000, 32'h0, 32'h0);
      check("pre_rst_rvalid", ifRvalid, 1);
      rst = 1'b1;
      ifReq = 1'b0;
      lsReq = 1'b0;
      if_exp_q.delete();
      ls_exp_q.delete();
      #1;
      check("rst_drop", {ifRvalid, ifRdata}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_starve = 0;
      step(1'b0, 32'h0, 1'b0, 3'b000, 32'h0, 32'h0);
      step(1'b0, 32'h0, 1'b0, 3'b000, 32'h0, 32'h0);
      step(1'b1, 32'h0000_0200, 1'b1, 3'b011, 32'h0000_0203, 32'h0);
      check("post_rst_first", {obs_if_gnt, obs_ls_gnt}, 2'b01);
      step(1'b0, 32'h0, 1'b0, 3'b000, 32'h0, 32'h0);
      #5;
      check("drain_if", if_exp_q.size(), 0);
      check("drain_ls", ls_exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
